// File: rtl/cache_victim_pkg.sv
// Shared types for the cache miss/victim controller.
// No logic; enum and helper constants only.
// No flow control here.
package cache_victim_pkg;

  // Miss-handling phases: wait for a miss, write back a dirty victim,
  // fill the new line, then retire the miss.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EVICT = 3'd1,
    FILL  = 3'd2,
    DONE  = 3'd3
  } statetype_t;

endpackage

// File: rtl/cache_beat_cnt.sv
// Beat index counter for line transfers; wraps modulo 2^W.
// Latency: count updates on the edge after clr_i/inc_i.
// Backpressure: holds its value whenever inc_i is low.
module cache_beat_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over increment so a new transfer always starts at beat 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Beat register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = &cnt_q;

endmodule

// File: rtl/cache_victim_ctrl.sv
// Miss controller: capture victim, optional dirty writeback, line fill, retire.
// Latency: clean miss BEATS+1 cycles, dirty miss 2*BEATS+1 cycles to Done.
// Backpressure: each bus beat waits for BusAck; everything holds without it.
module cache_victim_ctrl
  import cache_victim_pkg::*;
#(
  parameter int NUMWAYS   = 4,
  parameter int SETLEN    = 9,
  parameter int TAGLEN    = 20,
  parameter int OFFSETLEN = 5,
  parameter int BEATS     = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           MissReq,
  input  logic                           FlushStage,
  input  logic [SETLEN-1:0]              MissSet,
  input  logic [TAGLEN-1:0]              MissTag,
  input  logic [NUMWAYS-1:0]             VictimWay,
  input  logic [NUMWAYS-1:0]             DirtyWay,
  input  logic [TAGLEN-1:0]              TagRead,
  input  logic                           BusAck,
  output logic                           LRUWriteEn,
  output logic                           ClearValid,
  output logic [NUMWAYS-1:0]             SelWay,
  output logic [SETLEN-1:0]              CapSet,
  output logic                           BusReq,
  output logic                           BusWrite,
  output logic [TAGLEN+SETLEN+OFFSETLEN-1:0] BusAdr,
  output logic [$clog2(BEATS)-1:0]       Beat,
  output logic                           FillEn,
  output logic                           SetValid,
  output logic                           ClearDirty,
  output logic                           Busy,
  output logic                           Done
);

  localparam int BW = $clog2(BEATS);
  localparam int ZW = OFFSETLEN - BW;

  statetype_t           state_q, state_d;
  logic [NUMWAYS-1:0]   sel_way_q, sel_way_d;
  logic [SETLEN-1:0]    cap_set_q, cap_set_d;
  logic [TAGLEN-1:0]    cap_tag_q, cap_tag_d;
  logic                 capture;
  logic                 on_bus;
  logic                 beat_clr;
  logic                 beat_inc;
  logic                 beat_last;
  logic [BW-1:0]        beat;
  logic [OFFSETLEN-1:0] offset;

  // Gated by reset_n so the capture strobes are low for the whole reset,
  // not just after the first edge.
  assign capture  = reset_n & (state_q == IDLE) & MissReq & ~FlushStage;
  assign on_bus   = (state_q == EVICT) | (state_q == FILL);
  assign beat_inc = on_bus & BusAck;
  // The last writeback beat restarts the count for the fill; the last fill
  // beat wraps to 0 on its own.
  assign beat_clr = capture | ((state_q == EVICT) & BusAck & beat_last);

  cache_beat_cnt #(
    .W(BW)
  ) u_beat_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (beat_clr),
    .inc_i   (beat_inc),
    .cnt_o   (beat),
    .last_o  (beat_last)
  );

  // Beat selects a word within the line; the low byte-offset bits are zero.
  assign offset = OFFSETLEN'(beat) << ZW;

  // Victim, set and tag are frozen from capture until the next capture.
  always_comb begin
    sel_way_d = sel_way_q;
    cap_set_d = cap_set_q;
    cap_tag_d = cap_tag_q;
    if (capture) begin
      sel_way_d = VictimWay;
      cap_set_d = MissSet;
      cap_tag_d = MissTag;
    end
  end

  // State and capture registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sel_way_q <= '0;
      cap_set_q <= '0;
      cap_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      sel_way_q <= sel_way_d;
      cap_set_q <= cap_set_d;
      cap_tag_q <= cap_tag_d;
    end
  end

  // Next state plus state-decoded outputs; the address mux picks the stored
  // tag for writeback and the missing tag for the fill.
  always_comb begin
    state_d    = state_q;
    BusReq     = 1'b0;
    BusWrite   = 1'b0;
    BusAdr     = '0;
    FillEn     = 1'b0;
    SetValid   = 1'b0;
    ClearDirty = 1'b0;
    Done       = 1'b0;
    Busy       = 1'b1;
    unique case (state_q)
      IDLE: begin
        Busy = 1'b0;
        if (capture) begin
          state_d = (|(VictimWay & DirtyWay)) ? EVICT : FILL;
        end
      end
      EVICT: begin
        BusReq   = 1'b1;
        BusWrite = 1'b1;
        BusAdr   = {TagRead, cap_set_q, offset};
        if (BusAck && beat_last) begin
          state_d = FILL;
        end
      end
      FILL: begin
        BusReq = 1'b1;
        BusAdr = {cap_tag_q, cap_set_q, offset};
        FillEn = BusAck;
        if (BusAck && beat_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        SetValid   = 1'b1;
        ClearDirty = 1'b1;
        Done       = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign LRUWriteEn = capture;
  assign ClearValid = capture;
  assign SelWay     = sel_way_q;
  assign CapSet     = cap_set_q;
  assign Beat       = beat;

endmodule

// File: tb/tb_cache_victim_ctrl.sv
// Self-checking bench for cache_victim_ctrl: directed scenarios plus a
// randomized run against a queue-of-expected-beats reference model.
// Inputs change at the falling edge; outputs are sampled 1 time unit later.
module tb_cache_victim_ctrl;

  localparam int NW = 4;
  localparam int SL = 9;
  localparam int TL = 20;
  localparam int OL = 5;
  localparam int BT = 4;
  localparam int BW = 2;
  localparam int AW = TL + SL + OL;

  logic          clk;
  logic          reset_n;
  logic          MissReq;
  logic          FlushStage;
  logic [SL-1:0] MissSet;
  logic [TL-1:0] MissTag;
  logic [NW-1:0] VictimWay;
  logic [NW-1:0] DirtyWay;
  logic [TL-1:0] TagRead;
  logic          BusAck;
  logic          LRUWriteEn;
  logic          ClearValid;
  logic [NW-1:0] SelWay;
  logic [SL-1:0] CapSet;
  logic          BusReq;
  logic          BusWrite;
  logic [AW-1:0] BusAdr;
  logic [BW-1:0] Beat;
  logic          FillEn;
  logic          SetValid;
  logic          ClearDirty;
  logic          Busy;
  logic          Done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic          wr;
    logic [AW-1:0] adr;
    logic [BW-1:0] beat;
  } beat_t;

  cache_victim_ctrl #(
    .NUMWAYS(NW), .SETLEN(SL), .TAGLEN(TL), .OFFSETLEN(OL), .BEATS(BT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .MissReq    (MissReq),
    .FlushStage (FlushStage),
    .MissSet    (MissSet),
    .MissTag    (MissTag),
    .VictimWay  (VictimWay),
    .DirtyWay   (DirtyWay),
    .TagRead    (TagRead),
    .BusAck     (BusAck),
    .LRUWriteEn (LRUWriteEn),
    .ClearValid (ClearValid),
    .SelWay     (SelWay),
    .CapSet     (CapSet),
    .BusReq     (BusReq),
    .BusWrite   (BusWrite),
    .BusAdr     (BusAdr),
    .Beat       (Beat),
    .FillEn     (FillEn),
    .SetValid   (SetValid),
    .ClearDirty (ClearDirty),
    .Busy       (Busy),
    .Done       (Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The victim presented at a capture must be one-hot.
  always @(negedge clk) begin
    #2;
    if (reset_n && MissReq && !FlushStage && !Busy) begin
      assert ($onehot(VictimWay)) else $error("victim not one-hot");
    end
  end

  // Beat address: tag, set, beat index, three zero byte-offset bits.
  function automatic logic [AW-1:0] mk_adr(input logic [TL-1:0] t, input logic [SL-1:0] s, input int b);
    logic [BW-1:0] bb;
    bb = b[BW-1:0];
    return {t, s, bb, 3'b000};
  endfunction

  task automatic idle_inputs();
    MissReq    = 1'b0;
    FlushStage = 1'b0;
    MissSet    = '0;
    MissTag    = '0;
    VictimWay  = '0;
    DirtyWay   = '0;
    TagRead    = '0;
    BusAck     = 1'b0;
  endtask

  task automatic test_reset();
    logic [AW+NW+SL+BW+11-1:0] obs;
    idle_inputs();
    reset_n = 1'b0;
    #2;
    obs = {LRUWriteEn, ClearValid, SelWay, CapSet, BusReq, BusWrite, BusAdr, Beat,
           FillEn, SetValid, ClearDirty, Busy, Done, 4'b0};
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h required 0", obs);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (Busy !== 1'b0 || BusReq !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: Busy=%b BusReq=%b required 0 0", Busy, BusReq);
    end
  endtask

  task automatic test_clean_miss();
    @(negedge clk);
    MissReq = 1'b1; MissSet = 9'h01A; MissTag = 20'hABCDE;
    VictimWay = 4'b0100; DirtyWay = 4'b0000; BusAck = 1'b1;
    #1;
    checks++;
    if (LRUWriteEn !== 1'b1 || ClearValid !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL clean_capture: LRU=%b CV=%b Busy=%b required 1 1 0", LRUWriteEn, ClearValid, Busy);
    end
    for (int i = 1; i <= BT; i++) begin
      @(negedge clk);
      MissReq = 1'b0;
      #1;
      checks++;
      if (BusReq !== 1'b1 || BusWrite !== 1'b0 || FillEn !== 1'b1 || SelWay !== 4'b0100 ||
          CapSet !== 9'h01A || Beat !== BW'(i-1) || LRUWriteEn !== 1'b0 ||
          BusAdr !== mk_adr(20'hABCDE, 9'h01A, i-1)) begin
        failures++;
        $display("FAIL clean_fill_%0d: req=%b wr=%b fe=%b sel=%b beat=%0d adr=%h required 1 0 1 0100 %0d %h",
                 i, BusReq, BusWrite, FillEn, SelWay, Beat, BusAdr, i-1, mk_adr(20'hABCDE, 9'h01A, i-1));
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (Done !== 1'b1 || SetValid !== 1'b1 || ClearDirty !== 1'b1 || BusReq !== 1'b0) begin
      failures++;
      $display("FAIL clean_done: Done=%b SV=%b CD=%b req=%b required 1 1 1 0", Done, SetValid, ClearDirty, BusReq);
    end
    @(negedge clk);
    #1;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      failures++;
      $display("FAIL clean_idle: Busy=%b Done=%b required 0 0", Busy, Done);
    end
    idle_inputs();
  endtask

  // Dirty miss; optional FlushStage held high while busy must not matter.
  task automatic test_dirty_miss(input logic flush_busy);
    @(negedge clk);
    MissReq = 1'b1; MissSet = 9'h155; MissTag = 20'h0F0F0; TagRead = 20'h12345;
    VictimWay = 4'b0001; DirtyWay = 4'b0001; BusAck = 1'b1;
    #1;
    for (int c = 1; c <= 2*BT + 1; c++) begin
      @(negedge clk);
      MissReq = 1'b0;
      FlushStage = flush_busy;
      #1;
      checks++;
      if (c <= BT) begin
        if (BusReq !== 1'b1 || BusWrite !== 1'b1 || Beat !== BW'(c-1) ||
            BusAdr !== mk_adr(20'h12345, 9'h155, c-1) || FillEn !== 1'b0) begin
          failures++;
          $display("FAIL dirty_evict_%0d flush=%b: req=%b wr=%b beat=%0d adr=%h required 1 1 %0d %h",
                   c, flush_busy, BusReq, BusWrite, Beat, BusAdr, c-1, mk_adr(20'h12345, 9'h155, c-1));
        end
      end else if (c <= 2*BT) begin
        if (BusReq !== 1'b1 || BusWrite !== 1'b0 || Beat !== BW'(c-BT-1) || FillEn !== 1'b1 ||
            BusAdr !== mk_adr(20'h0F0F0, 9'h155, c-BT-1)) begin
          failures++;
          $display("FAIL dirty_fill_%0d flush=%b: req=%b wr=%b beat=%0d adr=%h required 1 0 %0d %h",
                   c, flush_busy, BusReq, BusWrite, Beat, BusAdr, c-BT-1, mk_adr(20'h0F0F0, 9'h155, c-BT-1));
        end
      end else begin
        if (Done !== 1'b1 || SetValid !== 1'b1 || ClearDirty !== 1'b1) begin
          failures++;
          $display("FAIL dirty_done flush=%b: Done=%b SV=%b CD=%b required 1 1 1", flush_busy, Done, SetValid, ClearDirty);
        end
      end
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_stall();
    int done_cyc;
    done_cyc = -1;
    @(negedge clk);
    MissReq = 1'b1; MissSet = 9'h0C3; MissTag = 20'h55AA5;
    VictimWay = 4'b1000; DirtyWay = 4'b0111; BusAck = 1'b1;
    #1;
    for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
      @(negedge clk);
      MissReq = 1'b0;
      BusAck = !(c >= 3 && c <= 5);
      #1;
      if (c >= 3 && c <= 5) begin
        checks++;
        if (BusReq !== 1'b1 || Beat !== 2'd2 || FillEn !== 1'b0 ||
            BusAdr !== mk_adr(20'h55AA5, 9'h0C3, 2)) begin
          failures++;
          $display("FAIL stall_hold_%0d: req=%b beat=%0d fe=%b adr=%h required 1 2 0 %h",
                   c, BusReq, Beat, FillEn, BusAdr, mk_adr(20'h55AA5, 9'h0C3, 2));
        end
      end
      if (Done === 1'b1) done_cyc = c;
    end
    checks++;
    if (done_cyc != BT + 1 + 3) begin
      failures++;
      $display("FAIL stall_latency: done at cycle %0d required %0d", done_cyc, BT + 4);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    MissReq = 1'b1; FlushStage = 1'b1; VictimWay = 4'b0010; DirtyWay = 4'b0010;
    #1;
    checks++;
    if (LRUWriteEn !== 1'b0 || ClearValid !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_strobe: LRU=%b CV=%b required 0 0", LRUWriteEn, ClearValid);
    end
    @(negedge clk);
    MissReq = 1'b0; FlushStage = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || BusReq !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle_nocap: Busy=%b BusReq=%b required 0 0", Busy, BusReq);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_evict();
    @(negedge clk);
    MissReq = 1'b1; MissSet = 9'h1FF; MissTag = 20'h00001; TagRead = 20'hFEDCB;
    VictimWay = 4'b0010; DirtyWay = 4'b1010; BusAck = 1'b1;
    #1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      MissReq = 1'b0;
      #1;
    end
    checks++;
    if (BusReq !== 1'b1 || BusWrite !== 1'b1 || Beat !== 2'd2) begin
      failures++;
      $display("FAIL abort_pre: req=%b wr=%b beat=%0d required 1 1 2", BusReq, BusWrite, Beat);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (BusReq !== 1'b0 || Busy !== 1'b0 || Beat !== '0 || SelWay !== '0 || CapSet !== '0 ||
        BusAdr !== '0 || FillEn !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset: req=%b busy=%b beat=%0d sel=%b set=%h adr=%h required all 0",
               BusReq, Busy, Beat, SelWay, CapSet, BusAdr);
    end
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit seen;
    @(negedge clk);
    MissReq = 1'b1; MissSet = 9'h0AA; MissTag = 20'h11111;
    VictimWay = 4'b0010; DirtyWay = 4'b0000; BusAck = 1'b1;
    #1;
    for (int c = 1; c <= BT; c++) begin
      @(negedge clk);
      VictimWay = 4'b1000; MissSet = 9'h0BB;
      #1;
    end
    @(negedge clk);
    #1;
    checks++;
    if (Done !== 1'b1 || LRUWriteEn !== 1'b0) begin
      failures++;
      $display("FAIL b2b_done: Done=%b LRU=%b required 1 0", Done, LRUWriteEn);
    end
    @(negedge clk);
    #1;
    checks++;
    if (LRUWriteEn !== 1'b1 || ClearValid !== 1'b1 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_recapture: LRU=%b CV=%b Busy=%b required 1 1 0", LRUWriteEn, ClearValid, Busy);
    end
    @(negedge clk);
    MissReq = 1'b0;
    #1;
    checks++;
    if (SelWay !== 4'b1000 || CapSet !== 9'h0BB || Busy !== 1'b1 || LRUWriteEn !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: sel=%b set=%h busy=%b lru=%b required 1000 0bb 1 0", SelWay, CapSet, Busy, LRUWriteEn);
    end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (Done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL b2b_drain: Done not seen within 20 cycles");
    end
    idle_inputs();
    @(negedge clk);
  endtask

  // Random traffic against a model that only knows which beats each miss owes.
  task automatic test_random(input int ncyc);
    beat_t         q[$];
    beat_t         e;
    int            phase;
    int            misses;
    logic [NW-1:0] m_sel;
    logic [SL-1:0] m_set;
    logic          cap;
    logic [5:0]    o6, x6;
    logic [AW+NW+SL+BW+6-1:0] ob, xb;
    phase = 0;
    misses = 0;
    m_sel = '0;
    m_set = '0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      MissReq    = ($urandom_range(0, 3) != 0);
      FlushStage = ($urandom_range(0, 3) == 0);
      MissSet    = SL'($urandom);
      MissTag    = TL'($urandom);
      VictimWay  = NW'(1 << $urandom_range(0, NW-1));
      DirtyWay   = NW'($urandom);
      BusAck     = ($urandom_range(0, 9) < 7);
      if (phase == 0) TagRead = TL'($urandom);
      #1;
      if (phase == 0) begin
        cap = MissReq & ~FlushStage;
        o6 = {LRUWriteEn, ClearValid, Busy, BusReq, Done, FillEn};
        x6 = {cap, cap, 4'b0000};
        checks++;
        if (o6 !== x6) begin
          failures++;
          $display("FAIL rand_idle cyc %0d: {lru,cv,busy,req,done,fe}=%b required %b", n, o6, x6);
        end
        if (cap) begin
          if (|(VictimWay & DirtyWay)) begin
            for (int b = 0; b < BT; b++) q.push_back('{1'b1, mk_adr(TagRead, MissSet, b), BW'(b)});
          end
          for (int b = 0; b < BT; b++) q.push_back('{1'b0, mk_adr(MissTag, MissSet, b), BW'(b)});
          m_sel = VictimWay;
          m_set = MissSet;
          phase = 1;
        end
      end else if (phase == 1) begin
        e = q[0];
        ob = {BusReq, BusWrite, FillEn, Busy, Done, LRUWriteEn, Beat, SelWay, CapSet, BusAdr};
        xb = {1'b1, e.wr, BusAck & ~e.wr, 1'b1, 1'b0, 1'b0, e.beat, m_sel, m_set, e.adr};
        checks++;
        if (ob !== xb) begin
          failures++;
          $display("FAIL rand_beat cyc %0d: {req,wr,fe,busy,done,lru,beat,sel,set,adr}=%h required %h", n, ob, xb);
        end
        if (BusAck) begin
          void'(q.pop_front());
          if (q.size() == 0) phase = 2;
        end
      end else begin
        o6 = {Done, SetValid, ClearDirty, Busy, BusReq, LRUWriteEn};
        x6 = 6'b111100;
        checks++;
        if (o6 !== x6 || SelWay !== m_sel) begin
          failures++;
          $display("FAIL rand_done cyc %0d: {done,sv,cd,busy,req,lru}=%b sel=%b required %b sel=%b",
                   n, o6, SelWay, x6, m_sel);
        end
        misses++;
        phase = 0;
      end
    end
    checks++;
    if (misses < 5) begin
      failures++;
      $display("FAIL rand_progress: completed %0d misses required at least 5", misses);
    end
    // Let any miss in flight finish so later activity starts from IDLE.
    MissReq = 1'b0;
    BusAck  = 1'b1;
    for (int c = 0; c < 20 && Busy === 1'b1; c++) @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss(1'b0);
    test_stall();
    test_flush_idle();
    test_dirty_miss(1'b1);
    test_reset_mid_evict();
    test_back_to_back();
    test_random(600);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
